// File: rtl/jacobian_transpose_step.sv
// -----------------------------------------------------------------------------
// jacobian_transpose_step
//
// Computes the inverse-kinematics joint update
//     dtheta = alpha * J^T * err
// from a 6x6 Jacobian, a 6-element pose error and a scalar step gain. All
// values are signed Q10.16 fixed point (W bits, FRAC fractional bits).
//
// A single signed W x W multiplier is shared in time:
//   MAC   : 36 cycles, joint c outer, task row r inner, acc += J[r][c]*err[r].
//           At the last row the column sum is scaled back to Q10.16,
//           saturated and stored in sum[c].
//   SCALE : 6 cycles, dtheta[k] = sat((alpha * sum[k]) >>> FRAC).
//   DONE  : result presented until the consumer accepts it.
// The result appears exactly 42 enabled clock edges after the accept edge.
//
// Ports
//   clk             system clock
//   rst             asynchronous, active-low reset
//   en              clock enable; when low every register holds
//   in_valid        jacobian_matrix / err / alpha are valid
//   in_ready        block is idle and can accept a transaction
//   jacobian_matrix J[r][c], r = task row (vx,vy,vz,wx,wy,wz), c = joint
//   err             pose error per task row
//   alpha           step gain
//   out_valid       dtheta is valid
//   out_ready       consumer accepts dtheta
//   dtheta          joint update per joint
//   sat_flag        at least one clamp happened in this transaction
//   busy            a transaction is in progress or waiting to be taken
// -----------------------------------------------------------------------------
module jacobian_transpose_step #(
    parameter int W     = 27,
    parameter int FRAC  = 16,
    parameter int ACC_W = 57
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [5:0][5:0][W-1:0]    jacobian_matrix,
    input  logic [5:0][W-1:0]         err,
    input  logic [W-1:0]              alpha,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [5:0][W-1:0]         dtheta,
    output logic                      sat_flag,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Result of a saturating narrow: the clamped value plus a clamp indicator.
    typedef struct packed {
        logic         clamped;
        logic [W-1:0] value;
    } sat_t;

    // Narrow an ACC_W-bit signed value to W bits with saturation. The value
    // fits exactly when every bit from W-1 upward equals the sign bit.
    function automatic sat_t sat_w(input logic signed [ACC_W-1:0] v);
        sat_t res;
        if ((&v[ACC_W-1:W-1]) || !(|v[ACC_W-1:W-1])) begin
            res.clamped = 1'b0;
            res.value   = v[W-1:0];
        end else begin
            res.clamped = 1'b1;
            res.value   = v[ACC_W-1] ? {1'b1, {(W-1){1'b0}}}
                                     : {1'b0, {(W-1){1'b1}}};
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                    state;
    logic [2:0]                r_idx;     // task row inside a column (MAC)
    logic [2:0]                c_idx;     // joint / column (MAC)
    logic [2:0]                k_idx;     // joint being scaled (SCALE)
    logic signed [ACC_W-1:0]   acc;
    logic [5:0][W-1:0]         sum_reg;   // J^T * err per joint, Q10.16

    // Captured operands; the inputs are free to change after the accept edge.
    logic [5:0][5:0][W-1:0]    j_reg;
    logic [5:0][W-1:0]         err_reg;
    logic [W-1:0]              alpha_reg;

    // -------------------------------------------------------------------------
    // Shared multiplier and result narrowing
    // -------------------------------------------------------------------------
    logic signed [W-1:0]       mul_a;
    logic signed [W-1:0]       mul_b;
    logic signed [2*W-1:0]     product;
    logic signed [ACC_W-1:0]   product_ext;
    logic signed [ACC_W-1:0]   acc_next;
    sat_t                      mac_sat;
    sat_t                      scale_sat;

    // NOTE: every variable gets a value before any conditional assignment so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        mul_a = j_reg[r_idx][c_idx];
        mul_b = err_reg[r_idx];
        if (state == SCALE) begin
            mul_a = alpha_reg;
            mul_b = sum_reg[k_idx];
        end
    end

    // Both operands are signed, so the full 2W-bit product is exact.
    assign product     = mul_a * mul_b;
    assign product_ext = {{(ACC_W-2*W){product[2*W-1]}}, product};
    assign acc_next    = acc + product_ext;

    // >>> on a signed operand is an arithmetic shift: floor rounding.
    assign mac_sat     = sat_w(acc_next >>> FRAC);
    assign scale_sat   = sat_w(product_ext >>> FRAC);

    // -------------------------------------------------------------------------
    // Operand capture
    // -------------------------------------------------------------------------
    // NOTE: these are pure datapath storage, always written before they are
    // read, so they are deliberately left out of reset; this keeps the large
    // register bank free of reset routing.
    always_ff @(posedge clk) begin
        if (en && (state == IDLE) && in_valid) begin
            j_reg     <= jacobian_matrix;
            err_reg   <= err;
            alpha_reg <= alpha;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM and result registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            r_idx    <= '0;
            c_idx    <= '0;
            k_idx    <= '0;
            acc      <= '0;
            sum_reg  <= '0;
            dtheta   <= '0;
            sat_flag <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sat_flag <= 1'b0;
                        r_idx    <= '0;
                        c_idx    <= '0;
                        acc      <= '0;
                        state    <= MAC;
                    end
                end

                MAC: begin
                    if (r_idx == 3'd5) begin
                        // Last row of this column: the sum includes the
                        // current product, then the accumulator restarts.
                        sum_reg[c_idx] <= mac_sat.value;
                        if (mac_sat.clamped) begin
                            sat_flag <= 1'b1;
                        end
                        acc   <= '0;
                        r_idx <= '0;
                        if (c_idx == 3'd5) begin
                            c_idx <= '0;
                            k_idx <= '0;
                            state <= SCALE;
                        end else begin
                            c_idx <= c_idx + 3'd1;
                        end
                    end else begin
                        acc   <= acc_next;
                        r_idx <= r_idx + 3'd1;
                    end
                end

                SCALE: begin
                    dtheta[k_idx] <= scale_sat.value;
                    if (scale_sat.clamped) begin
                        sat_flag <= 1'b1;
                    end
                    if (k_idx == 3'd5) begin
                        k_idx <= '0;
                        state <= DONE;
                    end else begin
                        k_idx <= k_idx + 3'd1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs are decoded straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_jacobian_transpose_step.sv
// -----------------------------------------------------------------------------
// tb_jacobian_transpose_step
//
// Directed bench for jacobian_transpose_step. Expected results are pushed to a
// scoreboard queue when a transaction is driven and popped when out_valid is
// seen. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_jacobian_transpose_step;

    localparam int     W    = 27;
    localparam longint MAXV = 67108863;
    localparam longint MINV = -67108864;

    typedef logic [5:0][5:0][W-1:0] jm_t;
    typedef logic [5:0][W-1:0]      vec_t;

    typedef struct {
        vec_t d;
        logic sat;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   en;
    logic   in_valid;
    logic   in_ready;
    jm_t    jacobian_matrix;
    vec_t   err;
    logic [W-1:0] alpha;
    logic   out_valid;
    logic   out_ready;
    vec_t   dtheta;
    logic   sat_flag;
    logic   busy;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    int     acc_cyc[$];
    exp_t   exp_q[$];

    jacobian_transpose_step #(.W(27), .FRAC(16), .ACC_W(57)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .jacobian_matrix (jacobian_matrix),
        .err             (err),
        .alpha           (alpha),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .dtheta          (dtheta),
        .sat_flag        (sat_flag),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Record the cycle number of every accepting edge.
    always @(posedge clk) begin
        cyc++;
        if (rst && en && in_valid && in_ready) begin
            acc_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mkvec(input int v0, input int v1, input int v2,
                                   input int v3, input int v4, input int v5);
        vec_t v;
        v[0] = W'(v0); v[1] = W'(v1); v[2] = W'(v2);
        v[3] = W'(v3); v[4] = W'(v4); v[5] = W'(v5);
        return v;
    endfunction

    function automatic longint clamp(input longint v, inout logic sat);
        if (v > MAXV) begin sat = 1'b1; return MAXV; end
        if (v < MINV) begin sat = 1'b1; return MINV; end
        return v;
    endfunction

    // Reference: dtheta = alpha * J^T * err with floor shifts and clamps.
    function automatic exp_t model(input jm_t j, input vec_t e, input logic [W-1:0] a);
        exp_t   x;
        longint s [6];
        longint acc;
        longint p;
        x.sat = 1'b0;
        for (int c = 0; c < 6; c++) begin
            acc = 0;
            for (int r = 0; r < 6; r++) begin
                acc += longint'($signed(j[r][c])) * longint'($signed(e[r]));
            end
            s[c] = clamp(acc >>> 16, x.sat);
        end
        for (int k = 0; k < 6; k++) begin
            p = clamp((longint'($signed(a)) * s[k]) >>> 16, x.sat);
            x.d[k] = p[W-1:0];
        end
        return x;
    endfunction

    function automatic exp_t mkexp(input vec_t d, input logic sat);
        exp_t x;
        x.d   = d;
        x.sat = sat;
        return x;
    endfunction

    function automatic jm_t fill_j(input int v);
        jm_t j;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                j[r][c] = W'(v);
        return j;
    endfunction

    function automatic jm_t ident_j();
        jm_t j = '0;
        for (int i = 0; i < 6; i++) j[i][i] = W'(65536);
        return j;
    endfunction

    // Step until out_valid, optionally dropping en for stall_len cycles once
    // stall_at edges have passed. n counts every edge after the accept edge.
    task automatic wait_done(input int stall_at, input int stall_len, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 300) begin
            if (stall_len > 0 && n == stall_at) begin
                en = 1'b0;
                repeat (stall_len) begin
                    tick();
                    n++;
                end
                en = 1'b1;
            end else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t x;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed result with empty scoreboard", tag);
        end else begin
            x = exp_q.pop_front();
            for (int i = 0; i < 6; i++)
                check($sformatf("%s_dtheta%0d", tag, i), dtheta[i], x.d[i]);
            check({tag, "_sat"}, sat_flag, x.sat);
        end
    endtask

    // One full transaction: accept, compute, optional backpressure, handshake.
    task automatic send(input string tag, input jm_t j, input vec_t e, input logic [W-1:0] a,
                        input int stall_len, input int hold);
        int   n;
        vec_t held;
        jacobian_matrix = j;
        err             = e;
        alpha           = a;
        in_valid        = 1'b1;
        check({tag, "_in_ready_idle"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        wait_done(10, stall_len, n);
        check({tag, "_latency"}, n, 42 + stall_len);
        compare_out(tag);
        held = dtheta;
        for (int i = 0; i < hold; i++) begin
            // A new request while DONE must be ignored.
            jacobian_matrix = fill_j(12345);
            in_valid        = 1'b1;
            tick();
            check($sformatf("%s_hold%0d_valid", tag, i), out_valid, 1'b1);
            check($sformatf("%s_hold%0d_in_ready", tag, i), in_ready, 1'b0);
            check($sformatf("%s_hold%0d_stable", tag, i), (dtheta == held), 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_released"}, out_valid, 1'b0);
        check({tag, "_in_ready_after"}, in_ready, 1'b1);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        jm_t  jt;
        jm_t  jr;
        vec_t er;
        vec_t e_id;
        vec_t e_sat;
        int   n;
        int   diff;

        rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        jacobian_matrix = '0; err = '0; alpha = '0;
        e_id  = mkvec(65536, 131072, -65536, 0, 32768, -32768);
        e_sat = mkvec(67108863, 67108863, 67108863, 67108863, 67108863, 67108863);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sat", sat_flag, 1'b0);
        check("rst_dtheta", dtheta, '0);
        rst = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1'b1);

        // Identity Jacobian, alpha = 0.5
        exp_q.push_back(mkexp(mkvec(32768, 65536, -32768, 0, 16384, -16384), 1'b0));
        send("ident", ident_j(), e_id, W'(32768), 0, 0);

        // Transpose: only column 3 populated
        jt = '0;
        jt[0][3] = W'(65536);
        jt[2][3] = W'(131072);
        exp_q.push_back(mkexp(mkvec(0, 0, 0, 196608, 0, 0), 1'b0));
        send("transp", jt, mkvec(65536, 0, 65536, 0, 0, 0), W'(65536), 0, 0);

        // Positive saturation with 10 cycles of backpressure
        exp_q.push_back(mkexp(e_sat, 1'b1));
        send("sat_pos", fill_j(67108863), e_sat, W'(65536), 0, 10);

        // Negative saturation
        exp_q.push_back(mkexp(mkvec(-67108864, -67108864, -67108864,
                                    -67108864, -67108864, -67108864), 1'b1));
        send("sat_neg", fill_j(67108863),
             mkvec(-67108863, -67108863, -67108863, -67108863, -67108863, -67108863),
             W'(65536), 0, 0);

        // Mixed data with a 5-cycle enable stall mid-MAC
        for (int r = 0; r < 6; r++) begin
            er[r] = W'(int'($urandom_range(0, 131072)) - 65536);
            for (int c = 0; c < 6; c++)
                jr[r][c] = W'(int'($urandom_range(0, 131072)) - 65536);
        end
        exp_q.push_back(model(jr, er, W'(40000)));
        send("stall", jr, er, W'(40000), 5, 0);

        // Reset in the middle of MAC
        jacobian_matrix = ident_j();
        err             = e_id;
        alpha           = W'(32768);
        in_valid        = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        rst = 1'b0;
        #1;
        check("midrst_dtheta", dtheta, '0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        exp_q.push_back(mkexp(mkvec(32768, 65536, -32768, 0, 16384, -16384), 1'b0));
        send("post_rst", ident_j(), e_id, W'(32768), 0, 0);

        // Back-to-back: in_valid and out_ready held high
        acc_cyc.delete();
        exp_q.push_back(mkexp(e_sat, 1'b1));
        jacobian_matrix = fill_j(67108863);
        err             = e_sat;
        alpha           = W'(65536);
        in_valid        = 1'b1;
        out_ready       = 1'b1;
        tick();
        jacobian_matrix = ident_j();
        err             = e_id;
        alpha           = W'(32768);
        exp_q.push_back(mkexp(mkvec(32768, 65536, -32768, 0, 16384, -16384), 1'b0));
        wait_done(0, 0, n);
        check("b2b_a_latency", n, 42);
        compare_out("b2b_a");
        tick();
        tick();
        in_valid = 1'b0;
        wait_done(0, 0, n);
        check("b2b_b_latency", n, 42);
        compare_out("b2b_b");
        tick();
        out_ready = 1'b0;
        check("b2b_idle", in_ready, 1'b1);
        check("b2b_accepts", acc_cyc.size(), 2);
        diff = (acc_cyc.size() >= 2) ? (acc_cyc[1] - acc_cyc[0]) : -1;
        check("b2b_interval", diff, 44);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
